// File: rtl/fu_div_pkg.sv
// Shared types and constants for the DIV functional-unit front-end.
// Op encodings, FSM states, sign/special-case flags and the RISC-V special-result rule.
package fu_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } div_state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic div_zero;
    logic ovf;
  } div_flags_t;

  function automatic logic op_is_signed(div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Result for divide-by-zero (div_zero=1) or signed overflow (div_zero=0).
  function automatic logic [31:0] special_result(div_op_e op, logic [31:0] a, logic div_zero);
    if (div_zero) return op_is_rem(op) ? a : ALL_ONES;
    return op_is_rem(op) ? '0 : INT_MIN;
  endfunction

endpackage

// File: rtl/fu_div_signfix.sv
// Combinational sign handling around an unsigned divider core: operand magnitudes and
// flags on the way in, sign restoration and RISC-V special-case substitution on the way out.
module fu_div_signfix
  import fu_div_pkg::*;
(
  input  div_op_e     in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  output div_flags_t  in_flags,

  input  div_op_e     fix_op,
  input  logic [31:0] fix_a,
  input  div_flags_t  fix_flags,
  input  logic [63:0] ip_data,
  output logic [31:0] fix_result
);

  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
    in_flags = '0;
    a_mag    = in_a;
    b_mag    = in_b;
    if (op_is_signed(in_op)) begin
      in_flags.neg_q = in_a[31] ^ in_b[31];
      in_flags.neg_r = in_a[31];
      in_flags.ovf   = (in_a == INT_MIN) && (in_b == ALL_ONES);
      if (in_a[31]) a_mag = -in_a;
      if (in_b[31]) b_mag = -in_b;
    end
    in_flags.div_zero = (in_b == '0);
  end

  always_comb begin
    q_fix = ip_data[63:32];
    r_fix = ip_data[31:0];
    if (fix_flags.neg_q) q_fix = -ip_data[63:32];
    if (fix_flags.neg_r) r_fix = -ip_data[31:0];
    fix_result = op_is_rem(fix_op) ? r_fix : q_fix;
    // The IP output is meaningless for these cases, so override it wholesale.
    if (fix_flags.div_zero || fix_flags.ovf)
      fix_result = special_result(fix_op, fix_a, fix_flags.div_zero);
  end

endmodule

// File: rtl/fu_div_ctrl.sv
// DIV functional-unit front-end: 2-way round-robin arbiter and single-op sequencer for an
// AXI-stream divider IP. Define DIV_ZERO_FASTPATH_EN to bypass the IP for b==0 / overflow ops.
module fu_div_ctrl
  import fu_div_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_op,
  input  logic [63:0]        req_a,
  input  logic [63:0]        req_b,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               div_a_valid,
  output logic [31:0]        div_a_data,
  output logic               div_b_valid,
  output logic [31:0]        div_b_data,
  input  logic               div_out_valid,
  input  logic [63:0]        div_out_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic [TAG_W-1:0]   res_tag
);

  div_state_e state_q, state_d;
  logic       rr_q, rr_d;

  div_op_e    op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] a_mag_q, a_mag_d;
  logic [31:0] b_mag_q, b_mag_d;
  div_flags_t flags_q, flags_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0] res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  logic             win;
  logic [1:0]       grant;
  logic             accept;
  div_op_e          sel_op;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      sel_a_mag;
  logic [31:0]      sel_b_mag;
  div_flags_t       sel_flags;
  logic [31:0]      fix_result;

  always_comb begin
    win = rr_q;
    if (!req_valid[rr_q]) win = ~rr_q;
    grant = '0;
    if (state_q == S_IDLE && req_valid[win]) grant[win] = 1'b1;
    accept  = |grant;
    sel_op  = win ? div_op_e'(req_op[3:2]) : div_op_e'(req_op[1:0]);
    sel_a   = win ? req_a[63:32] : req_a[31:0];
    sel_b   = win ? req_b[63:32] : req_b[31:0];
    sel_tag = win ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
  end

  fu_div_signfix u_signfix (
    .in_op      (sel_op),
    .in_a       (sel_a),
    .in_b       (sel_b),
    .a_mag      (sel_a_mag),
    .b_mag      (sel_b_mag),
    .in_flags   (sel_flags),
    .fix_op     (op_q),
    .fix_a      (a_q),
    .fix_flags  (flags_q),
    .ip_data    (div_out_data),
    .fix_result (fix_result)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    op_d       = op_q;
    a_d        = a_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    flags_d    = flags_q;
    tag_d      = tag_q;
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rr_d    = ~win;
          op_d    = sel_op;
          a_d     = sel_a;
          a_mag_d = sel_a_mag;
          b_mag_d = sel_b_mag;
          flags_d = sel_flags;
          tag_d   = sel_tag;
          // A flush in the accept cycle consumes the op but never starts it.
          if (!flush) begin
            state_d = S_ISSUE;
`ifdef DIV_ZERO_FASTPATH_EN
            if (sel_flags.div_zero || sel_flags.ovf) begin
              state_d    = S_DONE;
              res_data_d = special_result(sel_op, sel_a, sel_flags.div_zero);
              res_tag_d  = sel_tag;
            end
`endif
          end
        end
      end
      S_ISSUE: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (div_out_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_DONE;
            res_data_d = fix_result;
            res_tag_d  = tag_q;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  if (flush || res_ready) state_d = S_IDLE;
      S_DRAIN: if (div_out_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      op_q       <= OP_DIV;
      a_q        <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      flags_q    <= '0;
      tag_q      <= '0;
      res_data_q <= '0;
      res_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      op_q       <= op_d;
      a_q        <= a_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      flags_q    <= flags_d;
      tag_q      <= tag_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
    end
  end

  assign req_ready   = grant;
  assign div_a_valid = (state_q == S_ISSUE);
  assign div_b_valid = (state_q == S_ISSUE);
  assign div_a_data  = a_mag_q;
  assign div_b_data  = b_mag_q;
  assign res_valid   = (state_q == S_DONE);
  assign res_data    = res_data_q;
  assign res_tag     = res_tag_q;

endmodule

// File: tb/tb_fu_div_ctrl.sv
// Self-checking bench for fu_div_ctrl with a fixed-latency divider IP model.
module tb_fu_div_ctrl;

  localparam int IP_LAT = 12;
  localparam int TAG_W  = 4;
`ifdef DIV_ZERO_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic [1:0]         req_valid = '0;
  logic [1:0]         req_ready;
  logic [3:0]         req_op = '0;
  logic [63:0]        req_a = '0;
  logic [63:0]        req_b = '0;
  logic [2*TAG_W-1:0] req_tag = '0;
  logic               div_a_valid, div_b_valid;
  logic [31:0]        div_a_data, div_b_data;
  logic               div_out_valid;
  logic [63:0]        div_out_data;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [31:0]        res_data;
  logic [TAG_W-1:0]   res_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int two_rdy = 0;

  fu_div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_a_valid(div_a_valid), .div_a_data(div_a_data),
    .div_b_valid(div_b_valid), .div_b_data(div_b_data),
    .div_out_valid(div_out_valid), .div_out_data(div_out_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req_ready == 2'b11) two_rdy <= two_rdy + 1;
    if (div_a_valid) pulses <= pulses + 1;
  end

  // Divider IP model: unsigned, fixed latency, never reset; garbage on a zero divisor.
  logic [IP_LAT-1:0] ip_v = '0;
  logic [63:0]       ip_d [IP_LAT];
  always @(posedge clk) begin
    ip_v[0] <= div_a_valid & div_b_valid;
    ip_d[0] <= (div_b_data == 0) ? 64'hDEAD_BEEF_DEAD_BEEF
                                 : {div_a_data / div_b_data, div_a_data % div_b_data};
    for (int i = 1; i < IP_LAT; i++) begin
      ip_v[i] <= ip_v[i-1];
      ip_d[i] <= ip_d[i-1];
    end
  end
  assign div_out_valid = ip_v[IP_LAT-1];
  assign div_out_data  = ip_d[IP_LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic sgn, rem;
    sgn = ~op[0];
    rem = op[1];
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  function automatic bit is_special(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_op(input int r, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag, input string name,
                          output bit ok, output int acc);
    @(posedge clk); #1;
    req_valid[r]          = 1'b1;
    req_op[2*r +: 2]      = op;
    req_a[32*r +: 32]     = a;
    req_b[32*r +: 32]     = b;
    req_tag[TAG_W*r +: TAG_W] = tag;
    ok = 1'b0;
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk({name, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid[r] = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk); #1 req_valid[r] = 1'b0;
  endtask

  task automatic wait_res(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i > 0 || !res_valid) @(negedge clk);
      if (res_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_res_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input int r, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] exp, input string name);
    bit ok;
    int acc, p0;
    bit sp;
    start_op(r, op, a, b, tag, name, ok, acc);
    if (!ok) return;
    p0 = pulses;
    @(negedge clk);
    wait_res(name, ok);
    if (!ok) return;
    sp = is_special(op, a, b);
    chk({name, "_data"}, res_data, exp);
    chk({name, "_tag"}, 32'(res_tag), 32'(tag));
    chk({name, "_latency"}, 32'(cyc - acc), (FAST && sp) ? 32'd1 : 32'(IP_LAT + 2));
    chk({name, "_ip_pulses"}, 32'(pulses - p0), (FAST && sp) ? 32'd0 : 32'd1);
  endtask

  typedef struct {
    int          r;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];

  initial begin
    bit ok;
    int acc, cnt, grants, w, p0;
    bit stable;
    logic [31:0] d0, ra, rb, ex;
    logic [3:0]  t0, rt;
    logic [1:0]  rop;
    int rr, sel;

    vt[0]  = '{0, 2'b00, 32'hFFFF_FFF9, 32'd2,         4'd3,  32'hFFFF_FFFD};
    vt[1]  = '{0, 2'b10, 32'hFFFF_FFF9, 32'd2,         4'd4,  32'hFFFF_FFFF};
    vt[2]  = '{1, 2'b11, 32'd7,         32'd0,         4'd5,  32'd7};
    vt[3]  = '{1, 2'b01, 32'd5,         32'd0,         4'd6,  32'hFFFF_FFFF};
    vt[4]  = '{0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7,  32'h8000_0000};
    vt[5]  = '{1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8,  32'h0};
    vt[6]  = '{0, 2'b00, 32'd7,         32'hFFFF_FFFE, 4'd9,  32'hFFFF_FFFD};
    vt[7]  = '{1, 2'b10, 32'd7,         32'hFFFF_FFFE, 4'd10, 32'd1};
    vt[8]  = '{0, 2'b01, 32'hFFFF_FFFF, 32'd2,         4'd11, 32'h7FFF_FFFF};
    vt[9]  = '{1, 2'b11, 32'd100,       32'd7,         4'd12, 32'd2};
    vt[10] = '{0, 2'b00, 32'd0,         32'd0,         4'd13, 32'hFFFF_FFFF};
    vt[11] = '{1, 2'b10, 32'hFFFF_FFFB, 32'd0,         4'd14, 32'hFFFF_FFFB};
    vt[12] = '{0, 2'b00, 32'h8000_0000, 32'd1,         4'd15, 32'h8000_0000};
    vt[13] = '{1, 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 4'd0,  32'hFFFF_FFFF};

    do_reset();
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_div_valid", 32'({div_a_valid, div_b_valid}), 32'd0);

    // Round-robin with both requesters held valid, starting from rr=req0.
    @(posedge clk); #1;
    req_op = {2'b01, 2'b01};
    req_a = {32'd200, 32'd100};
    req_b = {32'd10, 32'd10};
    req_tag = {4'd2, 4'd1};
    req_valid = 2'b11;
    for (int g = 0; g < 3; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (req_ready != 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin chk("arb_grant_timeout", 32'd0, 32'd1); break; end
      w = req_ready[1] ? 1 : 0;
      chk($sformatf("arb_grant%0d", g), 32'(w), 32'(g % 2));
      if (g == 2) begin @(posedge clk); #1 req_valid = 2'b00; end
      @(negedge clk);
      wait_res("arb", ok);
      if (!ok) break;
      chk($sformatf("arb_tag%0d", g), 32'(res_tag), w ? 32'd2 : 32'd1);
      chk($sformatf("arb_data%0d", g), res_data, w ? 32'd20 : 32'd10);
    end
    req_valid = 2'b00;

    for (int i = 0; i < 14; i++)
      run_op(vt[i].r, vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rr  = $urandom_range(0, 1);
      rop = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      rt  = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin
        ra = 32'($urandom_range(0, 40)) - 32'd20;
        rb = 32'($urandom_range(1, 9));
        if ($urandom_range(0, 1) == 1) rb = -rb;
      end
      ex = ref_div(rop, ra, rb);
      run_op(rr, rop, ra, rb, rt, ex, $sformatf("rnd%0d", i));
    end

    // Flush while the op is in flight on the IP.
    start_op(0, 2'b00, 32'd1000, 32'd7, 4'd5, "flush_wait", ok, acc);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    cnt = 0;
    repeat (IP_LAT + 8) begin @(negedge clk); if (res_valid) cnt++; end
    chk("flush_wait_no_res", 32'(cnt), 32'd0);
    run_op(1, 2'b00, 32'hFFFF_FF9C, 32'd7, 4'd6, ref_div(2'b00, 32'hFFFF_FF9C, 32'd7), "post_flush");

    // Flush coinciding with the accept.
    p0 = pulses;
    @(posedge clk); #1;
    req_op[1:0] = 2'b01; req_a[31:0] = 32'd50; req_b[31:0] = 32'd5; req_tag[3:0] = 4'd9;
    req_valid[0] = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_acc_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 begin req_valid = 2'b00; flush = 1'b0; end
    cnt = 0;
    repeat (IP_LAT + 8) begin @(negedge clk); if (res_valid) cnt++; end
    chk("flush_acc_no_res", 32'(cnt), 32'd0);
    chk("flush_acc_no_issue", 32'(pulses - p0), 32'd0);

    // Flush while the result is waiting in DONE.
    res_ready = 1'b0;
    start_op(0, 2'b11, 32'd50, 32'd8, 4'd2, "flush_done", ok, acc);
    @(negedge clk);
    wait_res("flush_done", ok);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_done_drop", 32'(res_valid), 32'd0);
    res_ready = 1'b1;

    // Back-pressure in DONE with a competing request pending.
    res_ready = 1'b0;
    start_op(0, 2'b00, 32'hFFFF_FF9C, 32'd7, 4'd9, "stall", ok, acc);
    req_op[3:2] = 2'b11; req_a[63:32] = 32'd50; req_b[63:32] = 32'd7; req_tag[7:4] = 4'd5;
    req_valid[1] = 1'b1;
    @(negedge clk);
    wait_res("stall", ok);
    d0 = res_data;
    t0 = res_tag;
    chk("stall_data", d0, 32'hFFFF_FFF2);
    chk("stall_tag", 32'(t0), 32'd9);
    stable = 1'b1;
    grants = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(res_valid && res_data == d0 && res_tag == t0)) stable = 1'b0;
      if (req_ready != 0) grants++;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    chk("stall_no_grant", 32'(grants), 32'd0);
    @(posedge clk); #1 res_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[1]) begin ok = 1'b1; break; end
    end
    chk("stall_next_grant", 32'(ok), 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    wait_res("stall_next", ok);
    chk("stall_next_data", res_data, 32'd1);
    chk("stall_next_tag", 32'(res_tag), 32'd5);

    // Reset mid-WAIT; the IP still delivers the stale result afterwards.
    start_op(1, 2'b01, 32'd1000, 32'd3, 4'd7, "rst_wait", ok, acc);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    repeat (IP_LAT + 8) begin @(negedge clk); if (res_valid) cnt++; end
    chk("rst_stale_no_res", 32'(cnt), 32'd0);
    chk("rst_stale_data", res_data, 32'd0);
    run_op(0, 2'b10, 32'd1000, 32'd3, 4'd4, 32'd1, "post_rst");

    chk("never_two_ready", 32'(two_rdy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
